// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and write-back per opcode, with a watchdog on memory waits.
module mips_multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       mem_to_reg,
  output logic [1:0] reg_dst,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       instr_done,
  output logic       err,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_EXEC     = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_ADDI_EX  = 4'd10;
  localparam logic [3:0] S_ADDI_WB  = 4'd11;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(MEM_TIMEOUT);

  logic [3:0]      state_q, state_d;
  logic [TO_W-1:0] wdog_q, wdog_d;
  logic            waiting, timeout;

  // The watchdog only runs while parked in a memory-wait state; any exit clears it.
  always_comb begin
    waiting = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    timeout = (MEM_TIMEOUT != 0) && waiting && !mem_ready && (wdog_q == TO_LIM);
    wdog_d  = (waiting && !mem_ready && !timeout) ? wdog_q + TO_W'(1) : '0;
  end

  always_comb begin
    state_d    = state_q;
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 2'd0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    alu_op     = 2'd0;
    pc_source  = 2'd0;
    instr_done = 1'b0;
    err        = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_en    = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          err     = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_R:         state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default: begin
            err     = 1'b1;
            state_d = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
        if (mem_ready) begin
          state_d = S_MEM_WB;
        end else if (timeout) begin
          err     = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        iord      = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (timeout) begin
          err     = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = S_R_WB;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 2'd1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_op     = 2'd1;
        pc_source  = 2'd1;
        pc_en      = zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_source  = 2'd2;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
    // Reset state is FETCH, whose decode would otherwise request memory.
    if (!rst_n) begin
      pc_en      = 1'b0;
      iord       = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      ir_write   = 1'b0;
      mem_to_reg = 1'b0;
      reg_dst    = 2'd0;
      reg_write  = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      alu_op     = 2'd0;
      pc_source  = 2'd0;
      instr_done = 1'b0;
      err        = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wdog_q  <= '0;
    end else begin
      state_q <= state_d;
      wdog_q  <= wdog_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Randomized scoreboard bench: each instruction's expected per-instruction
// signature is queued by the driver and compared when instr_done/err pulses.
module tb_mips_multicycle_ctrl;

  localparam int TO = 15;
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg;
  logic [1:0] reg_dst, alu_src_b, alu_op, pc_source;
  logic       reg_write, alu_src_a, instr_done, err;
  logic [3:0] state;
  logic [17:0] all_outs;

  mips_multicycle_ctrl #(.MEM_TIMEOUT(TO), .TO_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .mem_to_reg(mem_to_reg), .reg_dst(reg_dst),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .instr_done(instr_done), .err(err),
    .state(state)
  );

  assign all_outs = {pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
                     reg_write, alu_src_a, alu_src_b, alu_op, pc_source, instr_done, err};

  always #5 clk = ~clk;

  // Per-instruction signature: cycle count plus how often each strobe fired
  // and the summed value of each select over the instruction's lifetime.
  typedef struct {
    bit is_err;
    int len, irw, rw, dst, m2r, mw, mr, pcen, pcsrc, srcb, aluop, srca, iord;
  } sig_t;

  sig_t sbq[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   nev = 0;
  bit   sb_on = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit mr);
    mem_ready = mr;
    @(posedge clk);
    #1;
  endtask

  // plan entries: 0/1 = mem_ready value, 2 = don't-care (randomized)
  task automatic run_instr(input logic [5:0] op, input bit z, input bit fto,
                           input int fstall, input int mstall);
    sig_t e;
    int   plan[$];
    opcode = op;
    zero   = z;
    if (fto) begin
      e = '{default: 0};
      e.is_err = 1'b1; e.len = TO + 1; e.mr = TO + 1; e.srcb = TO + 1;
      sbq.push_back(e); pushed++;
      repeat (TO + 1) plan.push_back(0);
    end
    e = '{default: 0};
    e.irw = 1; e.pcen = 1; e.mr = fstall + 1; e.srcb = fstall + 1 + 3; e.len = fstall + 2;
    repeat (fstall) plan.push_back(0);
    plan.push_back(1);
    plan.push_back(2);
    case (op)
      OP_R: begin
        e.len += 2; e.rw = 1; e.dst = 1; e.srca = 1; e.aluop = 2;
        plan.push_back(2); plan.push_back(2);
      end
      OP_ADDI: begin
        e.len += 2; e.rw = 1; e.srca = 1; e.srcb += 2;
        plan.push_back(2); plan.push_back(2);
      end
      OP_LW, OP_SW: begin
        e.len += 1; e.srca = 1; e.srcb += 2;
        plan.push_back(2);
        if (mstall > TO) begin
          e.is_err = 1'b1; e.len += TO + 1; e.iord = TO + 1;
          if (op == OP_LW) e.mr += TO + 1; else e.mw = TO + 1;
          repeat (TO + 1) plan.push_back(0);
        end else begin
          e.len += mstall + 1; e.iord = mstall + 1;
          if (op == OP_LW) e.mr += mstall + 1; else e.mw = mstall + 1;
          repeat (mstall) plan.push_back(0);
          plan.push_back(1);
          if (op == OP_LW) begin
            e.len += 1; e.rw = 1; e.m2r = 1;
            plan.push_back(2);
          end
        end
      end
      OP_BEQ: begin
        e.len += 1; e.srca = 1; e.aluop = 1;
        if (z) begin e.pcen = 2; e.pcsrc = 1; end
        plan.push_back(2);
      end
      OP_J: begin
        e.len += 1; e.pcen = 2; e.pcsrc = 2;
        plan.push_back(2);
      end
      default: e.is_err = 1'b1;
    endcase
    sbq.push_back(e); pushed++;
    foreach (plan[i]) cyc(plan[i] == 2 ? 1'($urandom_range(0, 1)) : (plan[i] == 1));
  endtask

  // Monitor: accumulate observed signature, compare on each retire/abort pulse.
  initial begin
    sig_t acc, e;
    acc = '{default: 0};
    forever begin
      @(negedge clk);
      if (sb_on && rst_n) begin
        acc.len++;
        acc.irw   += int'(ir_write);
        acc.rw    += int'(reg_write);
        acc.dst   += int'(reg_dst);
        acc.m2r   += int'(mem_to_reg);
        acc.mw    += int'(mem_write);
        acc.mr    += int'(mem_read);
        acc.pcen  += int'(pc_en);
        acc.pcsrc += pc_en ? int'(pc_source) : 0;
        acc.srcb  += int'(alu_src_b);
        acc.aluop += int'(alu_op);
        acc.srca  += int'(alu_src_a);
        acc.iord  += int'(iord);
        if (instr_done || err) begin
          nev++;
          if (sbq.size() == 0) begin
            chk("sb_underflow", 1, 0);
          end else begin
            e = sbq.pop_front();
            chk("err",        int'(err),        int'(e.is_err));
            chk("instr_done", int'(instr_done), int'(!e.is_err));
            chk("cycles",     acc.len,   e.len);
            chk("ir_write",   acc.irw,   e.irw);
            chk("reg_write",  acc.rw,    e.rw);
            chk("reg_dst",    acc.dst,   e.dst);
            chk("mem_to_reg", acc.m2r,   e.m2r);
            chk("mem_write",  acc.mw,    e.mw);
            chk("mem_read",   acc.mr,    e.mr);
            chk("pc_en",      acc.pcen,  e.pcen);
            chk("pc_source",  acc.pcsrc, e.pcsrc);
            chk("alu_src_b",  acc.srcb,  e.srcb);
            chk("alu_op",     acc.aluop, e.aluop);
            chk("alu_src_a",  acc.srca,  e.srca);
            chk("iord",       acc.iord,  e.iord);
          end
          acc = '{default: 0};
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [5:0] ops[6];
    logic [5:0] op;
    int fs, ms;
    ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI};
    rst_n = 1'b0; mem_ready = 1'b1; opcode = OP_R; zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", int'(state), 0);
    chk("rst_outs", int'(all_outs), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("fetch_ir_write", int'(ir_write), 1);
    chk("fetch_pc_en", int'(pc_en), 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("exec_state", int'(state), 6);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_state", int'(state), 0);
    chk("midrst_outs", int'(all_outs), 0);
    @(posedge clk); #1;
    chk("held_rst_outs", int'(all_outs), 0);

    rst_n = 1'b1;
    sb_on = 1'b1;
    run_instr(OP_R,    1'b0, 1'b0, 0, 0);
    run_instr(OP_LW,   1'b0, 1'b0, 0, 3);
    run_instr(OP_BEQ,  1'b1, 1'b0, 0, 0);
    run_instr(OP_BEQ,  1'b0, 1'b0, 0, 0);
    run_instr(OP_J,    1'b0, 1'b0, 0, 0);
    run_instr(OP_R,    1'b0, 1'b1, 0, 0);
    run_instr(OP_ADDI, 1'b0, 1'b1, 1, 0);
    run_instr(6'h3F,   1'b0, 1'b0, 0, 0);
    run_instr(OP_ADDI, 1'b1, 1'b0, 0, 0);
    run_instr(OP_SW,   1'b0, 1'b0, 1, 2);
    run_instr(OP_LW,   1'b0, 1'b0, 0, TO);
    run_instr(OP_LW,   1'b0, 1'b0, 0, TO + 1);
    run_instr(OP_SW,   1'b1, 1'b0, 2, TO + 1);
    run_instr(OP_SW,   1'b0, 1'b0, TO, TO);
    for (int n = 0; n < 200; n++) begin
      op = ($urandom_range(0, 6) == 6) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      case ($urandom_range(0, 9))
        8:       fs = TO;
        default: fs = $urandom_range(0, 3);
      endcase
      case ($urandom_range(0, 9))
        8:       ms = TO;
        9:       ms = TO + 1;
        default: ms = $urandom_range(0, 3);
      endcase
      run_instr(op, 1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0), fs, ms);
    end
    sb_on = 1'b0;
    mem_ready = 1'b0;
    repeat (3) @(posedge clk);
    chk("sb_empty", sbq.size(), 0);
    chk("events", nev, pushed);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
